// File: rtl/cu_pkg.sv
// Shared definitions for the instruction-sequencing control unit:
// 5-bit opcode constants (IR[31:27]) and the control-step state encoding.
// No logic; imported by control_unit and by anything that decodes opcodes.
package cu_pkg;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_SHR  = 5'd9;
   localparam logic [4:0] OP_SHRA = 5'd10;
   localparam logic [4:0] OP_SHL  = 5'd11;
   localparam logic [4:0] OP_ADDI = 5'd12;
   localparam logic [4:0] OP_ANDI = 5'd13;
   localparam logic [4:0] OP_ORI  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15;
   localparam logic [4:0] OP_MUL  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   localparam logic [4:0] OP_BR   = 5'd19;
   localparam logic [4:0] OP_JAL  = 5'd20;
   localparam logic [4:0] OP_JR   = 5'd21;
   localparam logic [4:0] OP_IN   = 5'd22;
   localparam logic [4:0] OP_OUT  = 5'd23;
   localparam logic [4:0] OP_MFLO = 5'd24;
   localparam logic [4:0] OP_MFHI = 5'd25;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   // Control steps T0..T7 are shared by all opcodes; the opcode selects
   // which strobes a step raises and which step ends the instruction.
   typedef enum logic [3:0] {
      S_RESET,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_T7,
      S_HALT,
      S_PAUSE
   } cu_state_t;

endpackage

// File: rtl/control_unit.sv
// Moore control-step sequencer: fetch (T0-T2) then opcode-dependent T3-T7.
// Ports: clock/clear (async active-low), IR/CON_FF/mem_ready/stop in;
//        datapath strobes, alu_op[4:0] and run out. Memory steps stall on mem_ready.
module control_unit
   import cu_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        mem_ready,
   input  logic        stop,
   output logic        PCout,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        LOout,
   output logic        HIout,
   output logic        MDRout,
   output logic        InPortout,
   output logic        Cout,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic        Zhighin,
   output logic        Zlowin,
   output logic        OutPortin,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        CONin,
   output logic [4:0]  alu_op,
   output logic        run
);

   cu_state_t   state, state_nxt;
   logic [4:0]  op;
   logic        is_alu_reg, is_alu_imm;
   logic        mem_wait;
   cu_state_t   last_step;
   cu_state_t   boundary;
   logic        unused_ir;

   // Only the opcode field matters to sequencing; operand fields feed the datapath.
   assign op        = IR[31:27];
   assign unused_ir = ^IR[26:0];

   assign is_alu_reg = (op >= OP_ADD)  && (op <= OP_SHL);
   assign is_alu_imm = (op >= OP_ADDI) && (op <= OP_ORI);

   // Step on which the current opcode finishes. Opcodes not listed (nop and
   // undefined values) finish at T2; halt is diverted separately.
   always_comb begin
      last_step = S_T2;
      if (is_alu_reg || is_alu_imm) begin
         last_step = S_T5;
      end else begin
         case (op)
            OP_LDI:                               last_step = S_T5;
            OP_LD, OP_ST:                         last_step = S_T7;
            OP_MUL, OP_DIV, OP_BR:                last_step = S_T6;
            OP_NEG, OP_NOT, OP_JAL:               last_step = S_T4;
            OP_JR, OP_IN, OP_OUT, OP_MFLO, OP_MFHI: last_step = S_T3;
            default:                              last_step = S_T2;
         endcase
      end
   end

   // Steps that own a memory cycle hold until the memory answers.
   assign mem_wait = !mem_ready &&
                     ((state == S_T1) ||
                      ((state == S_T6) && (op == OP_LD)) ||
                      ((state == S_T7) && (op == OP_ST)));

   // stop is only looked at here, so a pause never splits an instruction.
   assign boundary = stop ? S_PAUSE : S_T0;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= S_RESET;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RESET: state_nxt = S_T0;
         S_T0:    state_nxt = S_T1;
         S_T1:    state_nxt = mem_wait ? S_T1 : S_T2;
         S_T2: begin
            if (op == OP_HALT)        state_nxt = S_HALT;
            else if (last_step == S_T2) state_nxt = boundary;
            else                      state_nxt = S_T3;
         end
         S_T3, S_T4, S_T5, S_T6, S_T7: begin
            if (mem_wait)                state_nxt = state;
            else if (state == last_step) state_nxt = boundary;
            else begin
               case (state)
                  S_T3:    state_nxt = S_T4;
                  S_T4:    state_nxt = S_T5;
                  S_T5:    state_nxt = S_T6;
                  S_T6:    state_nxt = S_T7;
                  default: state_nxt = S_T0;
               endcase
            end
         end
         S_HALT:  state_nxt = S_HALT;
         S_PAUSE: state_nxt = stop ? S_PAUSE : S_T0;
         default: state_nxt = S_RESET;
      endcase
   end

   // Output decode from the registered step (plus opcode / CON_FF qualifiers).
   always_comb begin
      PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; LOout = 1'b0;
      HIout = 1'b0; MDRout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
      MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
      HIin = 1'b0; LOin = 1'b0; Zhighin = 1'b0; Zlowin = 1'b0; OutPortin = 1'b0;
      IncPC = 1'b0; Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0;
      Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; CONin = 1'b0;
      alu_op = 5'd0;
      run = 1'b0;

      case (state)
         S_T0: begin
            run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
         end
         S_T1: begin
            run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin
            run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            run = 1'b1;
            if (is_alu_reg || is_alu_imm) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end else begin
               case (op)
                  OP_NEG, OP_NOT: begin
                     Grb = 1'b1; Rout = 1'b1; alu_op = op; Zlowin = 1'b1;
                  end
                  OP_MUL, OP_DIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                  OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                  OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                  OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                  OP_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                  OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                  OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  default: ;
               endcase
            end
         end
         S_T4: begin
            run = 1'b1;
            if (is_alu_reg) begin
               Grc = 1'b1; Rout = 1'b1; alu_op = op; Zlowin = 1'b1;
            end else if (is_alu_imm) begin
               Cout = 1'b1; alu_op = op; Zlowin = 1'b1;
            end else begin
               case (op)
                  OP_NEG, OP_NOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_MUL, OP_DIV: begin
                     Grb = 1'b1; Rout = 1'b1; alu_op = op; Zhighin = 1'b1; Zlowin = 1'b1;
                  end
                  OP_LD, OP_LDI, OP_ST: begin Cout = 1'b1; alu_op = OP_ADD; Zlowin = 1'b1; end
                  OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
                  OP_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                  default: ;
               endcase
            end
         end
         S_T5: begin
            run = 1'b1;
            if (is_alu_reg || is_alu_imm) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else begin
               case (op)
                  OP_MUL, OP_DIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                  OP_LD, OP_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
                  OP_LDI:         begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_BR:          begin Cout = 1'b1; alu_op = OP_ADD; Zlowin = 1'b1; end
                  default: ;
               endcase
            end
         end
         S_T6: begin
            run = 1'b1;
            case (op)
               OP_MUL, OP_DIV: begin Zhighout = 1'b1; HIin = 1'b1; end
               OP_LD:          begin Read = 1'b1; MDRin = 1'b1; end
               OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               OP_BR:          begin Zlowout = 1'b1; PCin = CON_FF; end
               default: ;
            endcase
         end
         S_T7: begin
            run = 1'b1;
            case (op)
               OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               OP_ST:   Write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe/alu_op/run vectors
// compared against hand-written expectations, including stalls, pause,
// mid-instruction reset and halt.
module tb_control_unit;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] IR;
   logic        CON_FF, mem_ready, stop;
   logic PCout, Zhighout, Zlowout, LOout, HIout, MDRout, InPortout, Cout;
   logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin;
   logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CONin;
   logic [4:0] alu_op;
   logic       run;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   control_unit dut (
      .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF),
      .mem_ready(mem_ready), .stop(stop),
      .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .LOout(LOout),
      .HIout(HIout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
      .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .CONin(CONin), .alu_op(alu_op), .run(run)
   );

   // Strobe bit positions in the packed observation vector.
   localparam logic [27:0] M_PCOUT    = 28'd1 << 27;
   localparam logic [27:0] M_ZHIGHOUT = 28'd1 << 26;
   localparam logic [27:0] M_ZLOWOUT  = 28'd1 << 25;
   localparam logic [27:0] M_LOOUT    = 28'd1 << 24;
   localparam logic [27:0] M_HIOUT    = 28'd1 << 23;
   localparam logic [27:0] M_MDROUT   = 28'd1 << 22;
   localparam logic [27:0] M_INPORT   = 28'd1 << 21;
   localparam logic [27:0] M_COUT     = 28'd1 << 20;
   localparam logic [27:0] M_MARIN    = 28'd1 << 19;
   localparam logic [27:0] M_PCIN     = 28'd1 << 18;
   localparam logic [27:0] M_MDRIN    = 28'd1 << 17;
   localparam logic [27:0] M_IRIN     = 28'd1 << 16;
   localparam logic [27:0] M_YIN      = 28'd1 << 15;
   localparam logic [27:0] M_HIIN     = 28'd1 << 14;
   localparam logic [27:0] M_LOIN     = 28'd1 << 13;
   localparam logic [27:0] M_ZHIGHIN  = 28'd1 << 12;
   localparam logic [27:0] M_ZLOWIN   = 28'd1 << 11;
   localparam logic [27:0] M_OUTPORT  = 28'd1 << 10;
   localparam logic [27:0] M_INCPC    = 28'd1 << 9;
   localparam logic [27:0] M_READ     = 28'd1 << 8;
   localparam logic [27:0] M_WRITE    = 28'd1 << 7;
   localparam logic [27:0] M_GRA      = 28'd1 << 6;
   localparam logic [27:0] M_GRB      = 28'd1 << 5;
   localparam logic [27:0] M_GRC      = 28'd1 << 4;
   localparam logic [27:0] M_RIN      = 28'd1 << 3;
   localparam logic [27:0] M_ROUT     = 28'd1 << 2;
   localparam logic [27:0] M_BAOUT    = 28'd1 << 1;
   localparam logic [27:0] M_CONIN    = 28'd1 << 0;

   localparam logic [27:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
   localparam logic [27:0] F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
   localparam logic [27:0] F2 = M_MDROUT | M_IRIN;

   logic [33:0] obs;
   assign obs = {run, alu_op,
                 PCout, Zhighout, Zlowout, LOout, HIout, MDRout, InPortout, Cout,
                 MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin,
                 IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CONin};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Compare the current step, then move to the next sampling point.
   task automatic step(input string tag, input logic [27:0] m, input logic [4:0] alu,
                       input logic r);
      check(tag, {30'd0, obs}, {30'd0, r, alu, m});
      @(negedge clock);
   endtask

   task automatic fetch(input string tag);
      step({tag, "_t0"}, F0, 5'd0, 1'b1);
      step({tag, "_t1"}, F1, 5'd0, 1'b1);
      step({tag, "_t2"}, F2, 5'd0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 1'b0; IR = 32'd0; CON_FF = 1'b0; mem_ready = 1'b1; stop = 1'b0;
      #1;
      check("reset_async", {30'd0, obs}, 64'd0);
      @(negedge clock);
      check("reset_held", {30'd0, obs}, 64'd0);
      clear = 1'b1;
      @(negedge clock);

      // add: six steps, alu_op only in T4, then straight back to T0
      IR = {5'd3, 27'h0};
      fetch("add");
      step("add_t3", M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
      step("add_t4", M_GRC | M_ROUT | M_ZLOWIN, 5'd3, 1'b1);
      step("add_t5", M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1);

      // ld with three stalled edges in T6 (T6 visible for four cycles)
      IR = {5'd0, 27'h123};
      fetch("ld");
      step("ld_t3", M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
      step("ld_t4", M_COUT | M_ZLOWIN, 5'd3, 1'b1);
      mem_ready = 1'b0;
      step("ld_t5", M_ZLOWOUT | M_MARIN, 5'd0, 1'b1);
      step("ld_t6a", M_READ | M_MDRIN, 5'd0, 1'b1);
      step("ld_t6b", M_READ | M_MDRIN, 5'd0, 1'b1);
      step("ld_t6c", M_READ | M_MDRIN, 5'd0, 1'b1);
      mem_ready = 1'b1;
      step("ld_t6d", M_READ | M_MDRIN, 5'd0, 1'b1);
      step("ld_t7", M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b1);

      // br not taken, then taken
      for (int k = 0; k < 2; k++) begin
         IR = {5'd19, 27'h0};
         CON_FF = (k == 1);
         fetch("br");
         step("br_t3", M_GRA | M_ROUT | M_CONIN, 5'd0, 1'b1);
         step("br_t4", M_PCOUT | M_YIN, 5'd0, 1'b1);
         step("br_t5", M_COUT | M_ZLOWIN, 5'd3, 1'b1);
         step(k == 1 ? "br_t6_taken" : "br_t6_not", M_ZLOWOUT | (k == 1 ? M_PCIN : 28'd0),
              5'd0, 1'b1);
      end
      CON_FF = 1'b0;

      // mul with stop raised mid-instruction: completes, then pauses
      IR = {5'd16, 27'h0};
      fetch("mul");
      stop = 1'b1;
      step("mul_t3", M_GRA | M_ROUT | M_YIN, 5'd0, 1'b1);
      step("mul_t4", M_GRB | M_ROUT | M_ZHIGHIN | M_ZLOWIN, 5'd16, 1'b1);
      step("mul_t5", M_ZLOWOUT | M_LOIN, 5'd0, 1'b1);
      step("mul_t6", M_ZHIGHOUT | M_HIIN, 5'd0, 1'b1);
      step("pause_a", 28'd0, 5'd0, 1'b0);
      step("pause_b", 28'd0, 5'd0, 1'b0);
      stop = 1'b0;
      step("pause_c", 28'd0, 5'd0, 1'b0);

      // jal (5 cycles) and mfhi (4 cycles)
      IR = {5'd20, 27'h0};
      fetch("jal");
      step("jal_t3", M_PCOUT | M_GRB | M_RIN, 5'd0, 1'b1);
      step("jal_t4", M_GRA | M_ROUT | M_PCIN, 5'd0, 1'b1);
      IR = {5'd25, 27'h0};
      fetch("mfhi");
      step("mfhi_t3", M_HIOUT | M_GRA | M_RIN, 5'd0, 1'b1);

      // st, reset asserted while T7 waits on memory
      IR = {5'd2, 27'h0};
      fetch("st");
      step("st_t3", M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
      step("st_t4", M_COUT | M_ZLOWIN, 5'd3, 1'b1);
      step("st_t5", M_ZLOWOUT | M_MARIN, 5'd0, 1'b1);
      mem_ready = 1'b0;
      step("st_t6", M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1);
      step("st_t7a", M_WRITE, 5'd0, 1'b1);
      check("st_t7b", {30'd0, obs}, {30'd0, 1'b1, 5'd0, M_WRITE});
      clear = 1'b0;
      #1;
      check("st_abort", {30'd0, obs}, 64'd0);
      @(negedge clock);
      check("st_abort_held", {30'd0, obs}, 64'd0);
      clear = 1'b1;
      mem_ready = 1'b1;
      IR = {5'd26, 27'h0};
      @(negedge clock);
      // nop: three steps, then next fetch
      fetch("nop");
      // opcode 31 is undefined and sequences like nop
      IR = {5'd31, 27'h0};
      fetch("undef");

      // halt: parked with everything low
      IR = {5'd27, 27'h0};
      fetch("halt");
      for (int i = 0; i < 20; i++) step("halt_hold", 28'd0, 5'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports `clock` (input, 1): rising-edge system clock.
REQ-002 SHALL have port `clear` (input, 1): asynchronous, active-low reset.
REQ-003 SHALL have port `IR` (input, 32): instruction register contents; opcode = IR[31:27].
REQ-004 SHALL have port `CON_FF` (input, 1): branch condition flip-flop result.
REQ-005 SHALL have port `mem_ready` (input, 1): memory completes the current Read/Write cycle.
REQ-006 SHALL have port `stop` (input, 1): pause request, honoured only at an instruction boundary.
REQ-007 SHALL have output strobes (each 1 bit), all active high:
- PCout, Zhighout, Zlowout, LOout, HIout, MDRout, InPortout, Cout
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin
- IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CONin
REQ-008 SHALL have port `alu_op` (output, 5): operation code presented to the ALU.
REQ-009 SHALL have port `run` (output, 1): high while executing, low in RESET, HALT and PAUSE.

Function
REQ-010 SHALL be a Moore FSM: all outputs are decoded from the registered state only; outputs not listed for a state are 0.
REQ-011 Fetch sequence, common to all instructions:
- T0: PCout, MARin, IncPC, Zlowin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
REQ-012 Register ALU ops (add, sub, and, or, shr, shra, shl, ror, rol):
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, alu_op=opcode, Zlowin.
- T5: Zlowout, Gra, Rin.
REQ-013 Immediate ops (addi, andi, ori): same as REQ-012, except T4 drives Cout in place of Grc/Rout.
REQ-014 neg, not:
- T3: Grb, Rout, alu_op, Zlowin.
- T4: Zlowout, Gra, Rin.
REQ-015 mul, div:
- T3: Gra, Rout, Yin.
- T4: Grb, Rout, alu_op, Zhighin, Zlowin.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
REQ-016 ld:
- T3: Grb, BAout, Yin.
- T4: Cout, alu_op=ADD, Zlowin.
- T5: Zlowout, MARin.
- T6: Read, MDRin.
- T7: MDRout, Gra, Rin.
REQ-017 ldi: T3–T4 as for ld; T5: Zlowout, Gra, Rin.
REQ-018 st:
- T3–T5 as for ld.
- T6: Gra, Rout, MDRin.
- T7: Write.
REQ-019 br:
- T3: Gra, Rout, CONin.
- T4: PCout, Yin.
- T5: Cout, alu_op=ADD, Zlowin.
- T6: Zlowout, plus PCin only if CON_FF=1.
REQ-020 jr: T3: Gra, Rout, PCin.
REQ-021 jal:
- T3: PCout, Grb, Rin.
- T4: Gra, Rout, PCin.
REQ-022 Single-step register moves:
- in: T3 InPortout, Gra, Rin.
- out: T3 Gra, Rout, OutPortin.
- mfhi: T3 HIout, Gra, Rin.
- mflo: T3 LOout, Gra, Rin.
REQ-023 nop and undefined opcodes SHALL return from T2 directly to T0.
REQ-024 halt SHALL enter HALT; HALT holds all strobes at 0 until reset.
REQ-025 Memory states SHALL hold while mem_ready=0, with strobes stable:
- T1 (fetch), ld T6, st T7.
- Advance on the first edge with mem_ready=1.
REQ-026 Instruction boundary: after the last step of an instruction, if stop=1 the FSM enters PAUSE; otherwise it enters T0.
REQ-027 PAUSE SHALL return to T0 on the first edge with stop=0.
REQ-028 Latency, in cycles, with mem_ready always 1:
- ALU reg/imm 6; mul/div 7; ld 8; st 8; br 7.
- jr, in, out, mfhi, mflo 4; jal 5; nop 3.
REQ-029 alu_op SHALL be 0 in every state not listed as driving it.

Reset
REQ-030 When clear=0, the FSM SHALL asynchronously enter RESET; all outputs are 0, run=0, alu_op=0.
REQ-031 On the first rising edge with clear=1, the FSM SHALL go RESET -> T0.
REQ-032 Reset asserted mid-instruction or during a memory wait SHALL abort immediately; no partial strobe survives.

Structure
REQ-033 Shared package `cu_pkg` SHALL hold:
- the 5-bit opcode constants: ld=0, ldi=1, st=2, add=3, sub=4, and=5, or=6, ror=7, rol=8, shr=9, shra=10, shl=11, addi=12, andi=13, ori=14, div=15, mul=16, neg=17, not=18, br=19, jal=20, jr=21, in=22, out=23, mflo=24, mfhi=25, nop=26, halt=27;
- the state enumeration.
REQ-034 SHALL be a single module with no sub-modules; the state register and output decode live in this module.

Verification
REQ-035 Reset, then fetch add (opcode 3), mem_ready=1 -> T0..T5 strobes exactly per REQ-011/012; alu_op=3 only in T4; next T0 at cycle 6.
REQ-036 ld with mem_ready low for 3 cycles in T6 -> Read and MDRin held 4 cycles; MDRout/Rin follow in T7; total 11 cycles.
REQ-037 br with CON_FF=0, then with CON_FF=1 -> PCin absent in T6, then present in T6.
REQ-038 stop=1 during mul -> mul completes at T6 (HIin), then PAUSE with run=0; stop=0 -> T0 on the next edge.
REQ-039 clear pulsed low during st T7 wait -> all outputs 0 immediately; after release, T0 with no Write.
REQ-040 halt (opcode 27) -> HALT after T2; all strobes 0 and run=0 for 20 cycles; opcode 31 instead -> behaves as nop.
